exp_operand_loader: RTL and testbench
=====================================

# exp_operand_loader

Word-serial front/back end for the `exponentiation` core. Accepts the five 512-bit operands (x, modulus, exponent, Rmodm, Rsquaredmodm) as a 32-bit valid/ready stream and assembles them in registers. It then holds `startExponentiation` and `multiplication_enable` until the core raises `done`, and returns `A_result` as a 32-bit valid/ready stream. It sits between the host/DMA word interface and the exponentiation core.

## Interface
- `WORD_W`, default 32: stream word width.
- `OP_W`, default 512: operand width; `OP_W % WORD_W == 0`. `NW = OP_W/WORD_W` = 16 words per operand.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `s_valid` input 1: input word valid.
- `s_ready` output 1: loader accepts word.
- `s_data` input WORD_W: input word.
- `m_valid` output 1: result word valid.
- `m_ready` input 1: consumer accepts result word.
- `m_data` output WORD_W: result word.
- `x`, `modulus`, `exponent`, `Rmodm`, `Rsquaredmodm` output OP_W each: operand registers, wired to the core.
- `startExponentiation` output 1: core start level.
- `multiplication_enable` output 1: core enable level.
- `done` input 1: core completion.
- `A_result` input OP_W: core result.
- `busy` output 1: high in every state except LOAD.

## Operation
- States: LOAD, RUN, UNLOAD.
- **LOAD**
  - `s_ready` = 1.
  - Word counter `wcnt` (0..NW-1) and operand index `opi` (0..4).
  - Operand order: x, modulus, exponent, Rmodm, Rsquaredmodm.
  - Each operand arrives least-significant word first: word k goes to bits [k·WORD_W +: WORD_W] of operand `opi`.
  - On each handshake (`s_valid && s_ready`), `wcnt` increments. When `wcnt` wraps from NW-1 to 0, `opi` increments.
  - The handshake on word 5·NW-1 (the 80th) moves the FSM to RUN.
- **RUN**
  - `startExponentiation` = `multiplication_enable` = 1.
  - Operand registers are frozen; `s_ready` = 0.
  - `done` is ignored in the first RUN cycle, which guards against a stale `done` from the previous job. It is sampled from the second RUN cycle onward.
  - On a sampled `done` = 1: capture `A_result` into the result register, set `ridx` = 0, go to UNLOAD.
  - `startExponentiation` and `multiplication_enable` drop in the same edge.
- **UNLOAD**
  - `m_valid` = 1.
  - `m_data` = result[ridx·WORD_W +: WORD_W], LSW first.
  - On `m_valid && m_ready`, `ridx` increments.
  - After handshake of word NW-1, go to LOAD with `wcnt` = `opi` = 0.
  - `m_data` is stable while `m_valid` && !`m_ready`.
- Operand registers keep their values after a job. A new load overwrites them word by word.
- Reset (`resetn` = 0 at a clock edge, in any state, including mid-load, mid-RUN, mid-UNLOAD):
  - FSM goes to LOAD; `wcnt`, `opi`, `ridx` = 0.
  - Operand and result registers = 0.
  - All outputs take their reset values in that same edge.
- Reset values: `s_ready` = 1 once `resetn` = 1 (0 while in reset); `m_valid` = 0; `m_data` = 0; `startExponentiation` = 0; `multiplication_enable` = 0; `busy` = 0; all operand outputs = 0.

## Timing
- `s_ready`, `m_valid`, `busy`, `startExponentiation` and `multiplication_enable` are registered state decodes, with no combinational path from `s_valid` or `m_ready`.
- Full throughput: one word per cycle in LOAD and UNLOAD when the partner is always ready or valid.
- Start latency: `startExponentiation` is high in the cycle after the 80th input handshake.
- Result latency: `m_valid` is high in the cycle after the sampled `done`. Word 0 of the result is presented in that cycle.
- Minimum job length: 80 load cycles + RUN (≥2 cycles) + 16 unload cycles.
- `done` held high across the UNLOAD→LOAD transition has no effect; `done` is only sampled in RUN.
- `s_valid` during RUN or UNLOAD is not accepted; the data is held by the producer.

## Test plan
1. **Basic load.** Reset, then stream 80 words:
   - x words = 0x1000_0000+k, modulus = 0x2000_0000+k, exponent = {0x0000_00bb, 15×0}, Rmodm = 0x4000_0000+k, Rsquaredmodm = 0x5000_0000+k.
   - Required: `x[31:0]` = 0x1000_0000, `x[511:480]` = 0x1000_000f, `exponent` = 512'hbb.
   - Required: `startExponentiation` rises exactly 1 cycle after the 80th handshake.
2. **Core handshake.** Use a core stub that asserts `done` 7 cycles after start, with `A_result` = 512'h5764fd96…cdec.
   - Required: start/enable high for 7 cycles.
   - Required: the 16 output words equal the result LSW first (word 0 = 0x5f22cdec); `busy` drops after word 15.
3. **Backpressure.** Random `s_valid` gaps on input and `m_ready` low 3 cycles on every other word on output.
   - Required: no word lost or duplicated.
   - Required: `m_data` stays stable while stalled.
4. **Stale done.** The stub holds `done` = 1 from the previous job into the next RUN.
   - Required: the first RUN cycle ignores it and the capture happens on the second RUN cycle.
   - Required: `s_ready` stays 0 throughout RUN.
5. **Reset mid-operation.** Pulse `resetn` low for 1 cycle at input word 37, and again in RUN and again at output word 5.
   - Required: all outputs at their reset values next cycle, and operands = 0.
   - Required: a full subsequent job completes correctly.
6. **Back-to-back jobs.** Two jobs with different vectors and no idle cycles between them.
   - Required: the second job's operands fully replace the first job's, and both results are returned in order.

Source files
------------

// File: rtl/exp_operand_loader.sv
// rtl/exp_operand_loader.sv - word-serial operand loader and result unloader for the exponentiation core
module exp_operand_loader #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 512
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic [OP_W-1:0]   x,
    output logic [OP_W-1:0]   modulus,
    output logic [OP_W-1:0]   exponent,
    output logic [OP_W-1:0]   Rmodm,
    output logic [OP_W-1:0]   Rsquaredmodm,
    output logic              startExponentiation,
    output logic              multiplication_enable,
    input  logic              done,
    input  logic [OP_W-1:0]   A_result,
    output logic              busy
);

    localparam int NW = OP_W / WORD_W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);
    localparam logic [2:0]    LAST_OP   = 3'd4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     wcnt;
    logic [2:0]        opi;
    logic [CW-1:0]     ridx;
    logic              run_armed;
    logic [OP_W-1:0]   x_q;
    logic [OP_W-1:0]   modulus_q;
    logic [OP_W-1:0]   exponent_q;
    logic [OP_W-1:0]   rmodm_q;
    logic [OP_W-1:0]   rsq_q;
    logic [OP_W-1:0]   result_q;
    logic              s_fire;
    logic              m_fire;
    logic              last_in;
    logic              last_out;
    logic              capture;

    // Outputs decode the state register only; s_ready is additionally held low during reset.
    assign s_ready               = resetn && (state == LOAD);
    assign m_valid               = (state == UNLOAD);
    assign startExponentiation   = (state == RUN);
    assign multiplication_enable = (state == RUN);
    assign busy                  = (state != LOAD);
    assign m_data                = (state == UNLOAD) ? result_q[ridx*WORD_W +: WORD_W] : '0;

    assign x            = x_q;
    assign modulus      = modulus_q;
    assign exponent     = exponent_q;
    assign Rmodm        = rmodm_q;
    assign Rsquaredmodm = rsq_q;

    assign s_fire   = s_valid && s_ready;
    assign m_fire   = m_valid && m_ready;
    assign last_in  = (opi == LAST_OP) && (wcnt == LAST_WORD);
    assign last_out = (ridx == LAST_WORD);
    // The first RUN cycle never captures, so a done left high by the previous job is ignored.
    assign capture  = (state == RUN) && run_armed && done;

    // Next-state logic for the load / run / unload sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (s_fire && last_in) state_nxt = RUN;
            RUN:     if (capture)           state_nxt = UNLOAD;
            UNLOAD:  if (m_fire && last_out) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Input word counter, operand index and the RUN-cycle arming flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wcnt      <= '0;
            opi       <= '0;
            run_armed <= 1'b0;
        end else begin
            run_armed <= (state == RUN);
            if (s_fire) begin
                if (wcnt == LAST_WORD) begin
                    wcnt <= '0;
                    opi  <= last_in ? 3'd0 : opi + 3'd1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

    // Operand registers: each accepted word lands in the slot selected by opi/wcnt.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q        <= '0;
            modulus_q  <= '0;
            exponent_q <= '0;
            rmodm_q    <= '0;
            rsq_q      <= '0;
        end else if (s_fire) begin
            case (opi)
                3'd0:    x_q[wcnt*WORD_W +: WORD_W]        <= s_data;
                3'd1:    modulus_q[wcnt*WORD_W +: WORD_W]  <= s_data;
                3'd2:    exponent_q[wcnt*WORD_W +: WORD_W] <= s_data;
                3'd3:    rmodm_q[wcnt*WORD_W +: WORD_W]    <= s_data;
                default: rsq_q[wcnt*WORD_W +: WORD_W]      <= s_data;
            endcase
        end
    end

    // Result capture on done, then word-serial readout LSW first.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            result_q <= '0;
            ridx     <= '0;
        end else if (capture) begin
            result_q <= A_result;
            ridx     <= '0;
        end else if (m_fire) begin
            ridx <= last_out ? '0 : ridx + 1'b1;
        end
    end

endmodule

// File: tb/tb_exp_operand_loader.sv
// tb/tb_exp_operand_loader.sv - directed self-checking bench for exp_operand_loader
module tb_exp_operand_loader;

    logic         clk;
    logic         resetn;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic [511:0] x;
    logic [511:0] modulus;
    logic [511:0] exponent;
    logic [511:0] Rmodm;
    logic [511:0] Rsquaredmodm;
    logic         startExponentiation;
    logic         multiplication_enable;
    logic         done;
    logic [511:0] A_result;
    logic         busy;

    int n_checks;
    int n_errors;

    logic [31:0]  vec [80];
    logic [511:0] exp_op [5];
    logic [31:0]  rw [16];

    exp_operand_loader #(.WORD_W(32), .OP_W(512)) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .s_valid               (s_valid),
        .s_ready               (s_ready),
        .s_data                (s_data),
        .m_valid               (m_valid),
        .m_ready               (m_ready),
        .m_data                (m_data),
        .x                     (x),
        .modulus               (modulus),
        .exponent              (exponent),
        .Rmodm                 (Rmodm),
        .Rsquaredmodm          (Rsquaredmodm),
        .startExponentiation   (startExponentiation),
        .multiplication_enable (multiplication_enable),
        .done                  (done),
        .A_result              (A_result),
        .busy                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Operand vectors: sel 0 is the basic-load pattern, 1 and 2 are alternates.
    task automatic set_vec(input int sel);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 16; k++) begin
                logic [31:0] w;
                if (sel == 0) begin
                    if (i == 2) w = (k == 0) ? 32'h0000_00bb : 32'h0;
                    else        w = (32'(i + 1) << 28) + 32'(k);
                end else if (sel == 1) begin
                    w = 32'h0a0b_0000 + (32'(i) << 12) + 32'(k * 3);
                end else begin
                    w = ~((32'(i + 1) << 28) + 32'(k));
                end
                vec[i*16 + k] = w;
                exp_op[i][k*32 +: 32] = w;
            end
        end
    endtask

    task automatic set_res(input int sel);
        for (int k = 0; k < 16; k++) begin
            if (sel == 0)      rw[k] = 32'h3c6e_0000 + 32'(k) * 32'h0101;
            else if (sel == 1) rw[k] = 32'hcafe_0000 + 32'(k);
            else               rw[k] = 32'hdead_0000 ^ (32'(k) << 20);
        end
        if (sel == 0) begin
            rw[0]  = 32'h5f22_cdec;
            rw[15] = 32'h5764_fd96;
        end
        for (int k = 0; k < 16; k++) A_result[k*32 +: 32] = rw[k];
    endtask

    // Starts and ends on a negedge; ends in the first RUN cycle for a full load.
    task automatic load_job(input bit gaps, input int stop_at);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < stop_at && cyc < 2000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = vec[k];
            end
            if (s_valid && s_ready) k++;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        check("load_count", 512'(k), 512'(stop_at));
        if (stop_at == 80) begin
            check("start_latency", 512'(startExponentiation), 512'(1));
            check("enable_latency", 512'(multiplication_enable), 512'(1));
            check("busy_run", 512'(busy), 512'(1));
        end
    endtask

    task automatic check_ops(input string tag);
        check({tag, "_x"}, x, exp_op[0]);
        check({tag, "_mod"}, modulus, exp_op[1]);
        check({tag, "_exp"}, exponent, exp_op[2]);
        check({tag, "_rm"}, Rmodm, exp_op[3]);
        check({tag, "_r2"}, Rsquaredmodm, exp_op[4]);
    endtask

    // Core stub: counts RUN cycles, raises done at cycle n unless done is already held.
    task automatic run_core(input int n, input bit hold);
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        while (startExponentiation && cyc < 200) begin
            cnt++;
            if (s_ready) check("s_ready_in_run", 512'(s_ready), 512'(0));
            if (!hold && cnt == n) done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (!hold) done = 1'b0;
        check("run_length", 512'(cnt), hold ? 512'(2) : 512'(n));
        check("unload_latency", 512'(m_valid), 512'(1));
    endtask

    // Reads result words; ends in LOAD when stop_at is 16.
    task automatic unload(input bit stall, input int stop_at);
        int idx;
        int cyc;
        int stall_cnt;
        idx = 0;
        cyc = 0;
        stall_cnt = 0;
        while (idx < stop_at && cyc < 500) begin
            check($sformatf("m_data_w%0d", idx), 512'(m_data), 512'(rw[idx]));
            if (!m_valid) check("m_valid_unload", 512'(m_valid), 512'(1));
            if (stall && idx[0] && stall_cnt < 3) begin
                m_ready = 1'b0;
                stall_cnt++;
            end else begin
                m_ready = 1'b1;
                stall_cnt = 0;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        check("unload_count", 512'(idx), 512'(stop_at));
        if (stop_at == 16) begin
            check("busy_after_unload", 512'(busy), 512'(0));
            check("m_valid_after_unload", 512'(m_valid), 512'(0));
            check("s_ready_after_unload", 512'(s_ready), 512'(1));
        end
    endtask

    task automatic pulse_reset(input string tag);
        resetn  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        done    = 1'b0;
        @(negedge clk);
        check({tag, "_s_ready"}, 512'(s_ready), 512'(0));
        check({tag, "_m_valid"}, 512'(m_valid), 512'(0));
        check({tag, "_m_data"}, 512'(m_data), 512'(0));
        check({tag, "_start"}, 512'(startExponentiation), 512'(0));
        check({tag, "_enable"}, 512'(multiplication_enable), 512'(0));
        check({tag, "_busy"}, 512'(busy), 512'(0));
        check({tag, "_ops"}, x | modulus | exponent | Rmodm | Rsquaredmodm, 512'(0));
        resetn = 1'b1;
        @(negedge clk);
        check({tag, "_s_ready_rel"}, 512'(s_ready), 512'(1));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        done     = 1'b0;
        A_result = '0;
        repeat (2) @(negedge clk);
        pulse_reset("reset");

        // Basic load and core handshake.
        set_vec(0);
        set_res(0);
        load_job(1'b0, 80);
        check("x_lsw", 512'(x[31:0]), 512'(32'h1000_0000));
        check("x_msw", 512'(x[511:480]), 512'(32'h1000_000f));
        check("exponent_bb", exponent, 512'hbb);
        check("mod_w1", 512'(modulus[63:32]), 512'(32'h2000_0001));
        check("r2_msw", 512'(Rsquaredmodm[511:480]), 512'(32'h5000_000f));
        run_core(7, 1'b0);
        unload(1'b0, 16);

        // Backpressure on both sides.
        set_vec(1);
        set_res(1);
        load_job(1'b1, 80);
        check_ops("bp");
        run_core(4, 1'b0);
        unload(1'b1, 16);

        // Stale done held into RUN, then held across UNLOAD->LOAD.
        set_vec(2);
        set_res(2);
        done = 1'b1;
        load_job(1'b0, 80);
        check_ops("stale");
        run_core(2, 1'b1);
        unload(1'b0, 16);
        done = 1'b0;

        // Back-to-back jobs with no idle cycles.
        set_vec(0);
        set_res(0);
        load_job(1'b0, 80);
        check_ops("b2b_a");
        run_core(3, 1'b0);
        unload(1'b0, 16);
        set_vec(1);
        set_res(1);
        load_job(1'b0, 80);
        check_ops("b2b_b");
        run_core(5, 1'b0);
        unload(1'b1, 16);

        // Reset mid-load, mid-RUN and mid-unload, then a full job.
        set_vec(2);
        set_res(2);
        load_job(1'b0, 37);
        pulse_reset("rst_load");
        load_job(1'b0, 80);
        @(negedge clk);
        pulse_reset("rst_run");
        load_job(1'b0, 80);
        run_core(3, 1'b0);
        unload(1'b0, 5);
        pulse_reset("rst_unload");
        set_vec(0);
        set_res(0);
        load_job(1'b1, 80);
        check_ops("post_rst");
        run_core(6, 1'b0);
        unload(1'b1, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
